mdio_master: RTL and testbench
==============================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, the number of clk cycles per MDC half-period (legal range 2..255).
REQ-002 SHALL have parameter PREAMBLE_EN, default 1: 1 sends a 32-bit all-ones preamble, 0 suppresses it.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_read  input  1  1 = read (OP=10), 0 = write (OP=01).
REQ-008 cmd_phy  input  5  PHY address.
REQ-009 cmd_reg  input  5  register address.
REQ-010 cmd_wdata  input  16  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  16  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  read turnaround error, valid with rsp_valid.
REQ-014 mdc  output  1  management clock to the PHY side.
REQ-015 mdio_out  output  1  serial data driven toward the shared line.
REQ-016 mdio_oe  output  1  tristate enable: 1 = master drives the line.
REQ-017 mdio_in  input  1  sampled value of the shared line.

Function
REQ-018 States SHALL be IDLE, PRE, FRAME, DONE; cmd_ready = 1 only in IDLE.
REQ-019 A command is accepted on a clk edge with cmd_valid && cmd_ready; all cmd_* fields are latched on that edge and later input changes are ignored.
REQ-020 Acceptance SHALL move to PRE if PREAMBLE_EN = 1, otherwise directly to FRAME.
REQ-021 Each serial bit occupies 2*CLK_DIV clk cycles: mdc = 0 for the first CLK_DIV, mdc = 1 for the next CLK_DIV.
REQ-022 mdc SHALL be 0 in IDLE and DONE.
REQ-023 mdio_out and mdio_oe SHALL change only on the clk edge that starts a bit (mdc 1->0 or entry from IDLE).
REQ-024 PRE SHALL send 32 bits of 1 with oe = 1.
REQ-025 FRAME SHALL send 32 bits MSB-first in this order: ST = 01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-026 Write: TA = 10 and DATA = cmd_wdata, with oe = 1 for all 32 bits.
REQ-027 Read: oe = 1 through REGAD, then oe = 0 for both TA bits and all DATA bits.
REQ-028 Read: mdio_in SHALL be sampled on the clk edge where mdc goes 0->1.
REQ-029 Read: the second TA sample must be 0; if it is 1, rsp_err = 1 and the data bits are still captured.
REQ-030 Read: DATA samples SHALL shift MSB-first into rsp_rdata.
REQ-031 After the final bit's high phase, the FSM SHALL enter DONE for one cycle with mdio_oe = 0 and mdc = 0, assert rsp_valid, then return to IDLE.
REQ-032 On a write, rsp_rdata = 0 and rsp_err = 0.
REQ-033 rsp_rdata and rsp_err SHALL hold their value until the next rsp_valid.
REQ-034 Total transaction latency from acceptance to rsp_valid = (64 or 32 bits) * 2*CLK_DIV + 1 clk cycles.
REQ-035 The bit counter (6 bits) and divider counter SHALL wrap cleanly; no extra or missing mdc pulses at PRE->FRAME or at frame end.
REQ-036 A cmd_valid held high during a transaction is not accepted until IDLE.
REQ-037 Back-to-back: a command presented while in IDLE the cycle after DONE SHALL be accepted immediately.
REQ-038 mdio_oe SHALL never be 1 during read TA/DATA bits, so there is no bus contention.

Reset
REQ-039 Reset asserted at any time, including mid-frame, SHALL immediately (asynchronously) force: state = IDLE, cmd_ready = 1, mdc = 0, mdio_oe = 0, mdio_out = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, all counters = 0.
REQ-040 An interrupted transaction SHALL produce no rsp_valid.
REQ-041 The first command after reset release is handled normally.

Verification
REQ-042 Write, CLK_DIV = 4, PREAMBLE_EN = 1, phy = 0x01, reg = 0x04, wdata = 0xA5C3 -> serial stream captured on mdc rising edges = 32 ones, 01 01 00001 00100 10 1010010111000011; rsp_valid exactly 513 cycles after accept; rsp_err = 0.
REQ-043 Read, phy = 0x1F, reg = 0x00, PHY model drives TA low then 0x1234 -> rsp_rdata = 0x1234, rsp_err = 0; mdio_oe = 0 for the last 18 bits.
REQ-044 Read with PHY absent (line pulled up, mdio_in = 1) -> rsp_rdata = 0xFFFF, rsp_err = 1.
REQ-045 PREAMBLE_EN = 0, CLK_DIV = 2, write -> exactly 32 mdc pulses; rsp_valid 129 cycles after accept.
REQ-046 Reset pulsed during bit 40 of a read -> mdc = 0 and mdio_oe = 0 in the same cycle, no rsp_valid; a subsequent write completes correctly.
REQ-047 Two commands back-to-back, with cmd_valid held high and fields changed mid-transaction -> second command is accepted the cycle after the first rsp_valid, and the first frame uses only its originally latched fields.

Source files
------------

// File: rtl/mdio_master.sv
// MDIO (clause-22) management master: optional 32-bit preamble, then a 32-bit frame.
// Reads hand the line to the PHY for TA and DATA.
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// PRE   | shifting out 32 preamble ones
// FRAME | shifting ST/OP/PHYAD/REGAD/TA/DATA, sampling read data
// DONE  | one-cycle completion, rsp_valid high
module mdio_master #(
  parameter int CLK_DIV     = 4,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] DIV_LOAD = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [5:0] BIT_LAST = 6'd63;
  localparam logic [5:0] BIT_FRAME0 = 6'd32;
  localparam logic [4:0] FI_TA0  = 5'd14;
  localparam logic [4:0] FI_TA1  = 5'd15;
  localparam logic [4:0] FI_DATA = 5'd16;

  logic [1:0]  state;
  logic [8:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  next_bit;
  logic [31:0] frame_sr;
  logic [31:0] frame_word;
  logic        is_read;
  logic        ta_err;
  logic [15:0] rdata_sr;

  assign cmd_ready = (state == S_IDLE);
  assign next_bit  = bit_cnt + 6'd1;
  assign frame_word = {2'b01, (cmd_read ? 2'b10 : 2'b01), cmd_phy, cmd_reg,
                       (cmd_read ? 2'b11 : 2'b10), (cmd_read ? 16'h0000 : cmd_wdata)};

  // bit_cnt runs 0..31 in PRE and 32..63 in FRAME, so bit_cnt[4:0] is the frame index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      frame_sr  <= '0;
      is_read   <= 1'b0;
      ta_err    <= 1'b0;
      rdata_sr  <= '0;
      mdc       <= 1'b0;
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            is_read  <= cmd_read;
            ta_err   <= 1'b0;
            rdata_sr <= '0;
            div_cnt  <= DIV_LOAD;
            mdc      <= 1'b0;
            mdio_oe  <= 1'b1;
            if (PREAMBLE_EN) begin
              state    <= S_PRE;
              bit_cnt  <= '0;
              frame_sr <= frame_word;
              mdio_out <= 1'b1;
            end else begin
              state    <= S_FRAME;
              bit_cnt  <= BIT_FRAME0;
              frame_sr <= {frame_word[30:0], 1'b0};
              mdio_out <= frame_word[31];
            end
          end
        end
        S_PRE, S_FRAME: begin
          if (div_cnt == '0) begin
            mdc <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state     <= S_DONE;
              mdio_oe   <= 1'b0;
              mdio_out  <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= is_read ? rdata_sr : 16'h0000;
              rsp_err   <= is_read & ta_err;
            end else begin
              state   <= next_bit[5] ? S_FRAME : S_PRE;
              bit_cnt <= next_bit;
              div_cnt <= DIV_LOAD;
              if (next_bit[5]) begin
                mdio_out <= frame_sr[31];
                frame_sr <= {frame_sr[30:0], 1'b0};
                mdio_oe  <= !(is_read && (next_bit[4:0] >= FI_TA0));
              end
            end
          end else begin
            div_cnt <= div_cnt - 9'd1;
            if (div_cnt == DIV_HALF) begin
              mdc <= 1'b1;
              if (state == S_FRAME && is_read) begin
                if (bit_cnt[4:0] == FI_TA1) ta_err <= mdio_in;
                if (bit_cnt[4:0] >= FI_DATA) rdata_sr <= {rdata_sr[14:0], mdio_in};
              end
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: table of directed transactions on two configurations
// (CLK_DIV=4 with preamble, CLK_DIV=2 without), plus reset and back-to-back sequences.
module tb_mdio_master;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid1 = 1'b0, cmd_valid2 = 1'b0;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_in = 1'b1;

  logic        ready1, rv1, err1, mdc1, out1, oe1;
  logic        ready2, rv2, err2, mdc2, out2, oe2;
  logic [15:0] rdata1, rdata2;

  logic        sel = 1'b0;
  logic        m_cmd_ready, m_rsp_valid, m_rsp_err, m_mdc, m_mdio_out, m_mdio_oe;
  logic [15:0] m_rsp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(4), .PREAMBLE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(ready1),
    .cmd_read(cmd_read), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1),
    .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1), .mdio_in(mdio_in)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(ready2),
    .cmd_read(cmd_read), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv2), .rsp_rdata(rdata2), .rsp_err(err2),
    .mdc(mdc2), .mdio_out(out2), .mdio_oe(oe2), .mdio_in(mdio_in)
  );

  assign m_cmd_ready = sel ? ready2 : ready1;
  assign m_rsp_valid = sel ? rv2 : rv1;
  assign m_rsp_rdata = sel ? rdata2 : rdata1;
  assign m_rsp_err   = sel ? err2 : err1;
  assign m_mdc       = sel ? mdc2 : mdc1;
  assign m_mdio_out  = sel ? out2 : out1;
  assign m_mdio_oe   = sel ? oe2 : oe1;

  typedef struct {
    bit          d2;
    bit          rd;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    int          mode;   // 0 = PHY absent, 1 = TA ok + data, 2 = bad TA + data
    logic [15:0] pdata;
    logic [63:0] exp_cap;
    logic [63:0] mask;
    int          rises;
    int          lat;
    int          oe0;
    logic [15:0] rdata;
    bit          err;
  } vec_t;

  localparam logic [63:0] MW = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MR = 64'hFFFF_FFFF_FFFC_0000;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic phy_bit(input int mode, input logic [15:0] d, input int fi);
    logic [15:0] t;
    if (mode == 0) return 1'b1;
    if (fi == 15) return (mode == 2);
    if (fi >= 16 && fi <= 31) begin
      t = d >> (31 - fi);
      return t[0];
    end
    return 1'b1;
  endfunction

  // Starts on the accept edge; watches the line until rsp_valid or the budget runs out.
  task automatic capture(input bit drop, input bit nrd, input logic [4:0] nphy,
                         input logic [4:0] nrg, input logic [15:0] nwd, input int mode,
                         input logic [15:0] pdata, input int pre,
                         output logic [63:0] cap, output int rises, output int oe0,
                         output int cnt, output bit got);
    logic prev;
    prev = 1'b0; cap = '0; rises = 0; oe0 = 0; cnt = 0; got = 1'b0;
    while (!got && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        if (drop) begin cmd_valid1 = 1'b0; cmd_valid2 = 1'b0; end
        cmd_read = nrd; cmd_phy = nphy; cmd_reg = nrg; cmd_wdata = nwd;
      end
      if (m_mdc && !prev) begin
        cap = {cap[62:0], m_mdio_out};
        if (!m_mdio_oe) oe0++;
        rises++;
        mdio_in = phy_bit(mode, pdata, rises - pre);
      end
      prev = m_mdc;
      if (m_rsp_valid) got = 1'b1;
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    logic [63:0] cap;
    int rises, oe0, cnt;
    bit got;
    sel = v.d2;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), 64'(m_cmd_ready), 64'd1);
    cmd_read = v.rd; cmd_phy = v.phy; cmd_reg = v.rg; cmd_wdata = v.wd; mdio_in = 1'b1;
    if (v.d2) cmd_valid2 = 1'b1; else cmd_valid1 = 1'b1;
    @(posedge clk);
    capture(1'b1, !v.rd, ~v.phy, ~v.rg, ~v.wd, v.mode, v.pdata, v.d2 ? 0 : 32,
            cap, rises, oe0, cnt, got);
    chk($sformatf("v%0d_done", idx), 64'(got), 64'd1);
    chk($sformatf("v%0d_latency", idx), 64'(cnt), 64'(v.lat));
    chk($sformatf("v%0d_mdc_pulses", idx), 64'(rises), 64'(v.rises));
    chk($sformatf("v%0d_stream", idx), cap & v.mask, v.exp_cap & v.mask);
    chk($sformatf("v%0d_oe_low_bits", idx), 64'(oe0), 64'(v.oe0));
    chk($sformatf("v%0d_rdata", idx), 64'(m_rsp_rdata), 64'(v.rdata));
    chk($sformatf("v%0d_err", idx), 64'(m_rsp_err), 64'(v.err));
    chk($sformatf("v%0d_done_mdc_oe", idx), {62'd0, m_mdc, m_mdio_oe}, 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_one_pulse", idx), {62'd0, m_rsp_valid, m_cmd_ready}, 64'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_hold", idx), {47'd0, m_rsp_err, m_rsp_rdata}, {47'd0, v.err, v.rdata});
  endtask

  logic [63:0] cap;
  int rises, oe0, cnt, rv_seen, mdc_seen;
  bit got, prev;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'h01, 5'h04, 16'hA5C3, 0, 16'h0000,
                {32'hFFFF_FFFF, 32'h5092_A5C3}, MW, 64, 513, 0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 5'h1F, 5'h00, 16'h0000, 1, 16'h1234,
                {32'hFFFF_FFFF, 32'h6F80_0000}, MR, 64, 513, 18, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 5'h00, 5'h01, 16'h0000, 0, 16'h0000,
                {32'hFFFF_FFFF, 32'h6004_0000}, MR, 64, 513, 18, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 5'h05, 5'h0A, 16'h0000, 2, 16'hBEEF,
                {32'hFFFF_FFFF, 32'h62A8_0000}, MR, 64, 513, 18, 16'hBEEF, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 5'h03, 5'h11, 16'h8001, 0, 16'h0000,
                {32'h0000_0000, 32'h51C6_8001}, MW, 32, 129, 0, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 5'h10, 5'h1F, 16'h0001, 0, 16'h0000,
                {32'hFFFF_FFFF, 32'h587E_0001}, MW, 64, 513, 0, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 5'h1F, 5'h1F, 16'h0000, 1, 16'h8001,
                {32'h0000_0000, 32'h6FFC_0000}, MR, 32, 129, 18, 16'h8001, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 5'h02, 5'h03, 16'h0000, 1, 16'h5A5A,
                {32'hFFFF_FFFF, 32'h610C_0000}, MR, 64, 513, 18, 16'h5A5A, 1'b0};

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("reset_ready", {63'd0, ready1}, 64'd1);
    chk("reset_lines", {60'd0, mdc1, oe1, out1, rv1}, 64'b0010);
    chk("reset_rsp", {47'd0, err1, rdata1}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // reset while mdc is high in bit 40 of a read
    sel = 1'b0;
    @(negedge clk);
    cmd_read = 1'b1; cmd_phy = 5'h1F; cmd_reg = 5'h00; mdio_in = 1'b1; cmd_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid1 = 1'b0;
    rises = 0; prev = 1'b0; cnt = 0;
    while (rises < 41 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (m_mdc && !prev) rises++;
      prev = m_mdc;
    end
    chk("midrst_reach_bit40", 64'(rises), 64'd41);
    chk("midrst_pre_lines", {62'd0, m_mdc, m_mdio_oe}, 64'b11);
    #3 reset = 1'b1;
    #1;
    chk("midrst_lines", {60'd0, m_mdc, m_mdio_oe, m_mdio_out, m_cmd_ready}, 64'b0011);
    chk("midrst_rsp", {46'd0, m_rsp_valid, m_rsp_err, m_rsp_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rv_seen = 0; mdc_seen = 0;
    repeat (700) begin
      @(negedge clk);
      if (m_rsp_valid) rv_seen++;
      if (m_mdc) mdc_seen++;
    end
    chk("midrst_no_rsp", 64'(rv_seen), 64'd0);
    chk("midrst_no_mdc", 64'(mdc_seen), 64'd0);
    run_txn(vecs[0], 8);

    // back-to-back with cmd_valid held and fields changed during the first frame
    sel = 1'b0;
    @(negedge clk);
    cmd_read = 1'b0; cmd_phy = 5'h01; cmd_reg = 5'h02; cmd_wdata = 16'h1111; cmd_valid1 = 1'b1;
    @(posedge clk);
    capture(1'b0, 1'b0, 5'h03, 5'h04, 16'h2222, 0, 16'h0000, 32, cap, rises, oe0, cnt, got);
    chk("b2b_first_done", 64'(got), 64'd1);
    chk("b2b_first_latency", 64'(cnt), 64'd513);
    chk("b2b_first_stream", cap, {32'hFFFF_FFFF, 32'h508A_1111});
    @(negedge clk);
    chk("b2b_idle_ready", {62'd0, m_cmd_ready, m_rsp_valid}, 64'b10);
    @(posedge clk);
    capture(1'b1, 1'b0, 5'h03, 5'h04, 16'h2222, 0, 16'h0000, 32, cap, rises, oe0, cnt, got);
    chk("b2b_second_done", 64'(got), 64'd1);
    chk("b2b_second_latency", 64'(cnt), 64'd513);
    chk("b2b_second_stream", cap, {32'hFFFF_FFFF, 32'h5192_2222});
    chk("b2b_second_rsp", {47'd0, m_rsp_err, m_rsp_rdata}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
